// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment check.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // An access of 2^size bytes must start on a 2^size byte boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
    logic [2:0] mask;
    mask = 3'((4'd1 << size) - 4'd1);
    return |(off & mask);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and lane replication, load lane
// extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [1:0]        size,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  input  logic              uns,
  output logic [STRB_W-1:0] strb,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata_ext
);

  logic [DATA_W-1:0] rdata_sh;

  always_comb begin
    strb      = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    rdata_sh  = rdata >> {off, 3'b000};
    case (size_e'(size))
      SZ_B: begin
        strb      = STRB_W'(1) << off;
        wdata_rep = {(STRB_W){wdata[7:0]}};
        rdata_ext = uns ? DATA_W'(rdata_sh[7:0]) : DATA_W'($signed(rdata_sh[7:0]));
      end
      SZ_H: begin
        strb      = STRB_W'(3) << off;
        wdata_rep = {(STRB_W/2){wdata[15:0]}};
        rdata_ext = uns ? DATA_W'(rdata_sh[15:0]) : DATA_W'($signed(rdata_sh[15:0]));
      end
      SZ_W: begin
        strb      = STRB_W'(4'hF) << off;
        wdata_rep = {(STRB_W/4){wdata[31:0]}};
        rdata_ext = uns ? DATA_W'(rdata_sh[31:0]) : DATA_W'($signed(rdata_sh[31:0]));
      end
      default: begin
        strb      = '1;
        wdata_rep = wdata;
        rdata_ext = rdata_sh;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core request at a time, runs a valid/ready
// memory access and returns one response per accepted request.
module lsu
  import lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_strb,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  localparam logic [1:0] IDLE = 2'(ST_IDLE);
  localparam logic [1:0] REQ  = 2'(ST_REQ);
  localparam logic [1:0] WAIT = 2'(ST_WAIT);
  localparam logic [1:0] RESP = 2'(ST_RESP);

  logic [1:0]        state, state_nxt;
  logic              ready_q;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [STRB_W-1:0] strb_q;

  logic              accept, bad;
  logic [1:0]        size_sel;
  logic [OFF_W-1:0]  off_sel;
  logic [STRB_W-1:0] strb_c;
  logic [DATA_W-1:0] wdata_c, rdata_c;

  // ready_q is only ever set while the FSM sits in IDLE.
  assign accept = ready_q & req_valid;
  assign bad    = (32'(req_size) > OFF_W) ||
                  misaligned(req_size, 3'(req_addr[OFF_W-1:0]));

  // Steer from the live request at accept time, from the latched one afterwards.
  assign size_sel = ready_q ? req_size : size_q;
  assign off_sel  = ready_q ? req_addr[OFF_W-1:0] : off_q;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .size      (size_sel),
    .off       (off_sel),
    .wdata     (req_wdata),
    .rdata     (mem_rdata),
    .uns       (uns_q),
    .strb      (strb_c),
    .wdata_rep (wdata_c),
    .rdata_ext (rdata_c)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad ? RESP : REQ;
      REQ:     if (mem_ready) state_nxt = we_q ? RESP : WAIT;
      WAIT:    if (mem_rvalid) state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      strb_q  <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == IDLE);
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= bad;
        size_q  <= req_size;
        off_q   <= req_addr[OFF_W-1:0];
        addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        wdata_q <= req_we ? wdata_c : '0;
        strb_q  <= req_we ? strb_c : '0;
        rdata_q <= '0;
      end
      if (state == WAIT && mem_rvalid) rdata_q <= rdata_c;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = (state == RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign mem_valid  = (state == REQ);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_strb   = strb_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a 32-bit instance for the main scenarios and a
// 64-bit instance for dword and upper-lane accesses.
module tb_lsu;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rv, we, un, mr, rvl;
  logic [1:0]  sz;
  logic [31:0] addr, wd, rdm;
  logic        req_ready, resp_valid, resp_err, mem_valid, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_strb;

  // 64-bit instance
  logic        rv_d, we_d, un_d, mr_d, rvl_d;
  logic [1:0]  sz_d;
  logic [31:0] addr_d;
  logic [63:0] wd_d, rdm_d;
  logic        req_ready_d, resp_valid_d, resp_err_d, mem_valid_d, mem_we_d;
  logic [63:0] resp_rdata_d, mem_wdata_d;
  logic [31:0] mem_addr_d;
  logic [7:0]  mem_strb_d;

  int n_vec = 0;
  int n_err = 0;
  int resp_cnt;

  lsu #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(rv), .req_ready(req_ready), .req_we(we), .req_size(sz),
    .req_unsigned(un), .req_addr(addr), .req_wdata(wd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_valid(mem_valid), .mem_ready(mr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_strb(mem_strb), .mem_rdata(rdm), .mem_rvalid(rvl)
  );

  lsu #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .resetn(resetn),
    .req_valid(rv_d), .req_ready(req_ready_d), .req_we(we_d), .req_size(sz_d),
    .req_unsigned(un_d), .req_addr(addr_d), .req_wdata(wd_d),
    .resp_valid(resp_valid_d), .resp_rdata(resp_rdata_d), .resp_err(resp_err_d),
    .mem_valid(mem_valid_d), .mem_ready(mr_d), .mem_we(mem_we_d), .mem_addr(mem_addr_d),
    .mem_wdata(mem_wdata_d), .mem_strb(mem_strb_d), .mem_rdata(rdm_d), .mem_rvalid(rvl_d)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    rv = 0; we = 0; un = 0; mr = 0; rvl = 0; sz = 0; addr = 0; wd = 0; rdm = 0;
    rv_d = 0; we_d = 0; un_d = 0; mr_d = 0; rvl_d = 0; sz_d = 0; addr_d = 0; wd_d = 0; rdm_d = 0;

    // reset state
    step(); step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_strb", mem_strb, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    resetn = 1'b1;
    step();
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_ready64", req_ready_d, 1);

    // store byte 0x103, memory ready immediately
    rv = 1; we = 1; sz = 2'd0; addr = 32'h103; wd = 32'hAB; mr = 1;
    step(); rv = 0;
    chk("sb_mem_valid", mem_valid, 1);
    chk("sb_mem_we", mem_we, 1);
    chk("sb_mem_addr", mem_addr, 32'h100);
    chk("sb_strb", mem_strb, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_ready_busy", req_ready, 0);
    chk("sb_resp_c1", resp_valid, 0);
    step();
    chk("sb_resp_c2", resp_valid, 1);
    chk("sb_err", resp_err, 0);
    chk("sb_rdata", resp_rdata, 0);
    chk("sb_mem_valid_c2", mem_valid, 0);
    step();
    chk("sb_resp_c3", resp_valid, 0);
    chk("sb_ready_c3", req_ready, 1);

    // load half signed 0x202, rvalid three cycles late
    rv = 1; we = 0; sz = 2'd1; un = 0; addr = 32'h202; mr = 1;
    step(); rv = 0;
    chk("lh_mem_valid", mem_valid, 1);
    chk("lh_mem_we", mem_we, 0);
    chk("lh_strb", mem_strb, 0);
    chk("lh_mem_addr", mem_addr, 32'h200);
    step();
    chk("lh_mem_valid_wait", mem_valid, 0);
    for (int i = 0; i < 3; i++) begin
      chk("lh_no_resp", resp_valid, 0);
      step();
    end
    rvl = 1; rdm = 32'h80010000;
    step(); rvl = 0; rdm = 0;
    chk("lh_resp", resp_valid, 1);
    chk("lh_rdata_s", resp_rdata, 32'hFFFF8001);
    chk("lh_err", resp_err, 0);
    step();
    chk("lh_resp_end", resp_valid, 0);

    // same load unsigned, rvalid on time: response at cycle 3
    rv = 1; un = 1;
    step(); rv = 0;
    step();
    rvl = 1; rdm = 32'h80010000;
    step(); rvl = 0;
    chk("lhu_resp", resp_valid, 1);
    chk("lhu_rdata", resp_rdata, 32'h00008001);
    step();

    // load byte signed at offset 1
    rv = 1; sz = 2'd0; un = 0; addr = 32'h301;
    step(); rv = 0;
    step();
    rvl = 1; rdm = 32'h0000F500;
    step(); rvl = 0;
    chk("lb_rdata", resp_rdata, 32'hFFFFFFF5);
    step();

    // misaligned word load: error at cycle 1, no memory access
    rv = 1; sz = 2'd2; addr = 32'h6;
    step(); rv = 0;
    chk("mis_resp", resp_valid, 1);
    chk("mis_err", resp_err, 1);
    chk("mis_mem_valid", mem_valid, 0);
    chk("mis_rdata", resp_rdata, 0);
    step();
    chk("mis_mem_valid2", mem_valid, 0);
    chk("mis_ready", req_ready, 1);

    // dword on the 32-bit instance is illegal
    rv = 1; sz = 2'd3; addr = 32'h0;
    step(); rv = 0;
    chk("sz3_err", resp_err, 1);
    chk("sz3_mem_valid", mem_valid, 0);
    step();

    // store half, mem_ready held low 5 cycles
    rv = 1; we = 1; sz = 2'd1; addr = 32'h12; wd = 32'h0000BEEF; mr = 0;
    resp_cnt = 0;
    step(); rv = 0; wd = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", mem_valid, 1);
      chk("stall_addr", mem_addr, 32'h10);
      chk("stall_wdata", mem_wdata, 32'hBEEFBEEF);
      chk("stall_strb", mem_strb, 4'b1100);
      if (resp_valid) resp_cnt++;
      step();
    end
    mr = 1;
    step(); mr = 0;
    chk("stall_resp", resp_valid, 1);
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) resp_cnt++;
      step();
    end
    chk("stall_resp_count", resp_cnt, 1);

    // reset while waiting for read data; late rvalid ignored
    rv = 1; we = 0; sz = 2'd2; addr = 32'h20; mr = 1;
    step(); rv = 0;
    step();
    chk("wr_in_wait", mem_valid, 0);
    resetn = 0;
    #1;
    chk("wr_ready_rst", req_ready, 0);
    chk("wr_resp_rst", resp_valid, 0);
    rvl = 1; rdm = 32'hDEADBEEF;
    step();
    resetn = 1;
    step();
    chk("wr_ready_after", req_ready, 1);
    chk("wr_no_resp", resp_valid, 0);
    step(); rvl = 0;
    chk("wr_no_resp2", resp_valid, 0);
    chk("wr_rdata", resp_rdata, 0);

    // reset while presenting a memory request: mem_valid drops at once
    rv = 1; we = 1; sz = 2'd2; addr = 32'h40; wd = 32'h1; mr = 0;
    step(); rv = 0;
    chk("rq_valid", mem_valid, 1);
    resetn = 0;
    #1;
    chk("rq_valid_drop", mem_valid, 0);
    #2 resetn = 1;
    step();
    chk("rq_ready_after", req_ready, 1);
    chk("rq_no_resp", resp_valid, 0);

    // 64-bit: dword store at 0x08
    rv_d = 1; we_d = 1; sz_d = 2'd3; addr_d = 32'h8; wd_d = 64'h1122334455667788; mr_d = 1;
    step(); rv_d = 0;
    chk("d_strb", mem_strb_d, 8'hFF);
    chk("d_addr", mem_addr_d, 32'h8);
    chk("d_wdata", mem_wdata_d, 64'h1122334455667788);
    step();
    chk("d_resp", resp_valid_d, 1);
    chk("d_err", resp_err_d, 0);
    step();

    // 64-bit: dword at 0x0C misaligned
    rv_d = 1; addr_d = 32'hC;
    step(); rv_d = 0;
    chk("dmis_resp", resp_valid_d, 1);
    chk("dmis_err", resp_err_d, 1);
    chk("dmis_mem_valid", mem_valid_d, 0);
    step();

    // 64-bit: word store in upper half
    rv_d = 1; sz_d = 2'd2; addr_d = 32'h4; wd_d = 64'hFFFF0000CAFEF00D;
    step(); rv_d = 0;
    chk("dw_strb", mem_strb_d, 8'hF0);
    chk("dw_wdata", mem_wdata_d, 64'hCAFEF00DCAFEF00D);
    chk("dw_addr", mem_addr_d, 32'h0);
    step(); step();

    // 64-bit: signed word load from upper half; rvalid already high in REQ is ignored
    rv_d = 1; we_d = 0; sz_d = 2'd2; un_d = 0; addr_d = 32'hC;
    rvl_d = 1; rdm_d = 64'h8000000100000000;
    step(); rv_d = 0;
    chk("dl_mem_valid", mem_valid_d, 1);
    chk("dl_addr", mem_addr_d, 32'h8);
    chk("dl_strb", mem_strb_d, 8'h00);
    step();
    chk("dl_no_resp", resp_valid_d, 0);
    step(); rvl_d = 0;
    chk("dl_resp", resp_valid_d, 1);
    chk("dl_rdata", resp_rdata_d, 64'hFFFFFFFF80000001);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Parametrised load/store unit between the multicycle core and data memory. It replaces the core's direct word-only memory access with byte, half and word (and dword when `DATA_W=64`) loads and stores. It generates byte strobes, lane replication and sign/zero extension, and detects misaligned accesses. Memory is reached through a valid/ready handshake, so it tolerates variable-latency memories and wait states. The core issues one request at a time and receives exactly one response per accepted request.

## Interface
- `DATA_W`, 32: memory/data width; legal values 32 or 64.
- `ADDR_W`, 32: byte address width.
- `STRB_W`, `DATA_W/8`: derived; lanes per memory word (not overridable).

- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core request present.
- `req_ready`  out  1  LSU can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- `req_unsigned`  in  1  zero-extend a load (1) or sign-extend it (0).
- `req_addr`  in  `ADDR_W`  byte address.
- `req_wdata`  in  `DATA_W`  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  `DATA_W`  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned or illegal size; valid with `resp_valid`.
- `mem_valid`  out  1  memory request.
- `mem_ready`  in  1  memory accepts the request.
- `mem_we`  out  1  write.
- `mem_addr`  out  `ADDR_W`  `req_addr` with its low log2(`STRB_W`) bits zeroed.
- `mem_wdata`  out  `DATA_W`  lane-replicated store data.
- `mem_strb`  out  `STRB_W`  byte enables; all 0 on reads.
- `mem_rdata`  in  `DATA_W`  read data.
- `mem_rvalid`  in  1  read data valid.

## Operation
- State machine `IDLE`, `REQ`, `WAIT`, `RESP`. Reset enters `IDLE`.
- `IDLE`:
  - `req_ready=1`.
  - On `req_valid`, latch `req_*`.
  - Legal request: go to `REQ`.
  - Misaligned request (`addr mod 2^size != 0`) or size above log2(`STRB_W`): set the error flag and go to `RESP`. No memory access is made.
- `REQ`:
  - `mem_valid=1`; `mem_*` are driven from the latched values and held stable until `mem_ready`.
  - On `mem_ready` with a store: go to `RESP`.
  - On `mem_ready` with a load: go to `WAIT`.
- `WAIT`: on `mem_rvalid`, capture `mem_rdata`, extract the lane at the byte offset, extend it to `DATA_W`, then go to `RESP`.
- `RESP`: `resp_valid=1` for exactly one cycle, then return to `IDLE`. There is no response backpressure.
- Strobes:
  - byte: `1<<off`.
  - half: `3<<off`.
  - word: `4'hF<<off` (offset 0 or 4 when `DATA_W=64`).
  - dword: all ones.
- Store data: the low `8<<size` bits of `req_wdata` are replicated across every lane.
- `mem_rvalid` is ignored outside `WAIT`. A `mem_ready` arriving when `mem_valid=0` is ignored.

## Timing
- Reset values (async, while `resetn=0`): state `IDLE`, latched registers 0.
  - `req_ready`, `resp_valid`, `resp_err`, `resp_rdata`, `mem_valid`, `mem_we`, `mem_strb`, `mem_addr`, `mem_wdata` all 0.
  - `req_ready` rises on the first cycle after `resetn` deasserts.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Latency, with request accepted at cycle 0:
  - `mem_valid` at cycle 1.
  - Store with `mem_ready` at cycle 1: `resp_valid` at cycle 2.
  - Load with `mem_ready` at cycle 1 and `mem_rvalid` at cycle 2: `resp_valid` at cycle 3.
  - Error: `resp_valid` at cycle 1.
- Each stall cycle on `mem_ready` or `mem_rvalid` adds one cycle. There is no timeout.
- Back-to-back operation: `req_ready` returns the cycle after `resp_valid`, so the minimum issue interval is 3 cycles for a store and 4 for a load.
- Reset mid-operation: `mem_valid` drops immediately. The outstanding access is abandoned and a late `mem_rvalid` is ignored.

## Structure
- Package `lsu_pkg`:
  - `size_e` enum (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_D`).
  - `state_e` enum.
  - `function` for the misalignment check.
- Sub-module `lsu_align` (combinational, parametrised by `DATA_W`):
  - inputs: size, offset, `wdata`, `rdata`, unsigned.
  - outputs: `strb`, replicated `wdata`, extended `rdata`.
- The top-level `lsu` holds the FSM and latches.

## Test plan
- Store byte, `addr=0x103`, `wdata=0xAB`, `mem_ready` immediate -> `mem_addr=0x100`, `strb=4'b1000`, `mem_wdata=0xABABABAB`, `resp_valid` at cycle 2, `err=0`.
- Load half signed, `addr=0x202`, `mem_rdata=0x80010000`, `rvalid` 3 cycles late -> `resp_rdata=0xFFFF8001`. Repeat unsigned -> `0x00008001`.
- Load word, `addr=0x06` -> `resp_err=1` at cycle 1, `mem_valid` never asserted.
- `mem_ready` held low 5 cycles -> `mem_addr`, `mem_wdata` and `mem_strb` stable throughout; exactly one `resp_valid`.
- `resetn` pulsed low while in `WAIT`, then `mem_rvalid` arrives -> no `resp_valid`; `req_ready=1` the cycle after release.
- `DATA_W=64`: dword store at `0x08` -> `strb=8'hFF`. Dword at `0x0C` -> `err=1`.
